tipi_rpi_shift_port: RTL and testbench
======================================

Name: tipi_rpi_shift_port

Overview:
- RPi-side end of the TIPI latch interface.
- The Raspberry Pi drives a slow GPIO serial protocol into the CPLD/FPGA fabric. This block uses that protocol to read the bytes the TI wrote into the data and control latches, and to write the RPi-to-TI data and control bytes that the TI reads back through the bus transmitters.
- Every RPi pin is asynchronous to the board clock. The block synchronises them, detects edges and runs a small framing state machine.

Parameters:
- SYNC_STAGES, 2, number of flops in each RPi-input synchroniser (minimum 2).
- TIMEOUT_CYCLES, 50000, clk cycles without an r_clk rising edge before an in-progress frame is aborted (1 ms at 50 MHz).
- TO_W, 16, width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  50 MHz board clock.
- rst_n  in  1  Asynchronous active-low reset.
- r_clk  in  1  RPi shift clock. Acts on the rising edge.
- r_le  in  1  RPi latch enable. Acts on the rising edge.
- r_rt  in  1  Direction select. 1 = RPi reads a TI-written byte. 0 = RPi writes a byte for the TI.
- r_cd  in  1  Register select. 1 = control byte. 0 = data byte.
- r_din  in  1  Serial data from RPi, MSB first.
- r_dout  out  1  Serial data to RPi, MSB first.
- td_in  in  8  TI-written data latch (asynchronous to clk).
- tc_in  in  8  TI-written control latch (asynchronous to clk).
- rd_out  out  8  RPi-written data byte, presented to the TI data transmitter.
- rc_out  out  8  RPi-written control byte, presented to the TI control transmitter.
- rd_strobe  out  1  One-cycle pulse when rd_out updates.
- rc_strobe  out  1  One-cycle pulse when rc_out updates.
- frame_err  out  1  One-cycle pulse on any protocol error.
- busy  out  1  High whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs go to 0. State goes to IDLE.
  - Shift register, bit_cnt, overrun flag, timeout counter and all synchroniser flops clear.
  - Reset asserted mid-frame discards the frame.
- Synchronisers and edge detect:
  - r_clk, r_le, r_rt, r_cd and r_din each pass through SYNC_STAGES flops.
  - clk_rise and le_rise are detected from the last two synchronised stages.
  - A pin edge is acted on SYNC_STAGES+1 clk cycles after it arrives.
- Edge priority: when clk_rise and le_rise fall in the same cycle, le_rise is processed and clk_rise is dropped.
- IDLE:
  - le_rise with rt=1 goes to CAPTURE.
  - clk_rise with rt=0 shifts r_din into the LSB, sets bit_cnt=1 and goes to RX.
  - le_rise with rt=0 pulses frame_err; no commit.
  - clk_rise with rt=1 is ignored.
- CAPTURE:
  - Each cycle, sample the selected source into cap_q: tc_in if cd=1, td_in if cd=0.
  - When two consecutive samples are equal, load the shift register, drive r_dout = bit7, set bit_cnt=0 and go to TX.
  - If no two consecutive samples match within 8 cycles, load the latest sample, pulse frame_err and go to TX anyway.
- TX:
  - Each clk_rise shifts left, drives r_dout with the next bit and increments bit_cnt.
  - The RPi samples r_dout before each rising edge.
  - The 8th clk_rise drives r_dout to 0 and returns to IDLE.
  - le_rise in TX pulses frame_err, then goes to CAPTURE if rt=1 or to IDLE if rt=0.
- RX:
  - Each clk_rise shifts r_din into the LSB. bit_cnt saturates at 8.
  - A clk_rise while bit_cnt=8 sets the sticky overrun flag.
  - le_rise with rt=0 and bit_cnt=8 and no overrun: commit the shift register to rc_out (cd=1) or rd_out (cd=0), pulse the matching strobe for one cycle, go to IDLE.
  - le_rise with rt=0 otherwise (short frame or overrun): pulse frame_err, no commit, go to IDLE.
  - le_rise with rt=1: pulse frame_err, abandon the write, go to CAPTURE.
- Timeout:
  - In TX or RX, the timeout counter increments every cycle and clears on clk_rise.
  - Reaching TIMEOUT_CYCLES pulses frame_err, clears bit_cnt and overrun, forces r_dout to 0 and goes to IDLE.
  - The counter is held at 0 in IDLE and CAPTURE.
- rd_out and rc_out hold their value until the next valid commit to that register. They never change on error.
- Leaving RX clears overrun. Entering RX from IDLE clears the shift register before the first bit.

Test Plan:
- Write data: rt=0, cd=0, r_din bits 1,0,1,0,0,1,0,1 on 8 r_clk pulses, then an r_le pulse -> rd_out=0xA5, rd_strobe high exactly 1 cycle, rc_out stays 0x00, frame_err never pulses.
- Read control: tc_in=0x3C, rt=1, cd=1, r_le pulse, then 8 r_clk pulses -> r_dout sampled before each rise = 0,0,1,1,1,1,0,0; busy falls after the 8th edge.
- Short and long writes: 5 clocks then le -> frame_err pulse, rd_out unchanged. 9 clocks then le -> frame_err pulse, no commit.
- Timeout recovery: 3 r_clk pulses, then silence for TIMEOUT_CYCLES -> frame_err pulse, busy=0. A following full write of 0x5A to cd=1 -> rc_out=0x5A.
- Unstable capture: td_in toggling 0x00/0xFF every clk, rt=1, cd=0, le pulse -> frame_err pulse within 8 cycles; TX proceeds with the last sample.
- Async reset after 4 RX bits and coincident clk/le edges -> all outputs 0 immediately. le_rise wins over a coincident clk_rise with no extra bit shifted.

Source files
------------

// File: rtl/tipi_rpi_shift_port_if.sv
// RPi pin bundle plus TI-side latch/transmitter buses of the TIPI shift port.
// master = RPi/TI environment, slave = the shift-port fabric block.
interface tipi_rpi_shift_port_if;
    logic       r_clk;
    logic       r_le;
    logic       r_rt;
    logic       r_cd;
    logic       r_din;
    logic       r_dout;
    logic [7:0] td_in;
    logic [7:0] tc_in;
    logic [7:0] rd_out;
    logic [7:0] rc_out;
    logic       rd_strobe;
    logic       rc_strobe;
    logic       frame_err;
    logic       busy;

    modport master (
        output r_clk, r_le, r_rt, r_cd, r_din, td_in, tc_in,
        input  r_dout, rd_out, rc_out, rd_strobe, rc_strobe, frame_err, busy
    );

    modport slave (
        input  r_clk, r_le, r_rt, r_cd, r_din, td_in, tc_in,
        output r_dout, rd_out, rc_out, rd_strobe, rc_strobe, frame_err, busy
    );
endinterface

// File: rtl/tipi_rpi_shift_port.sv
// RPi-side TIPI latch port: synchronised GPIO serial framing to read TI latches and write RPi bytes.
// Pin edges act SYNC_STAGES+1 clk later; no backpressure, the RPi paces everything.
module tipi_rpi_shift_port #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tipi_rpi_shift_port_if.slave port
);

    typedef enum logic [1:0] {IDLE, CAPTURE, TX, RX} state_t;

    // clk/le carry one extra history stage so the edge is taken from the last two stages
    logic [SYNC_STAGES:0]   clk_s, le_s;
    logic [SYNC_STAGES-1:0] rt_s, cd_s, din_s;

    logic clk_rise, le_rise, rt, cd, din;

    state_t          state, state_n;
    logic [7:0]      sh, sh_n;
    logic [3:0]      bit_cnt, bit_cnt_n;
    logic            ovr, ovr_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic [7:0]      cap_q, cap_q_n;
    logic [2:0]      cap_cnt, cap_cnt_n;
    logic            dout_q, dout_n;
    logic [7:0]      rd_q, rd_n, rc_q, rc_n;
    logic            rd_stb, rd_stb_n, rc_stb, rc_stb_n, err, err_n;
    logic [7:0]      src;
    logic            to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s <= '0;
            le_s  <= '0;
            rt_s  <= '0;
            cd_s  <= '0;
            din_s <= '0;
        end else begin
            clk_s <= {clk_s[SYNC_STAGES-1:0], port.r_clk};
            le_s  <= {le_s[SYNC_STAGES-1:0],  port.r_le};
            rt_s  <= {rt_s[SYNC_STAGES-2:0],  port.r_rt};
            cd_s  <= {cd_s[SYNC_STAGES-2:0],  port.r_cd};
            din_s <= {din_s[SYNC_STAGES-2:0], port.r_din};
        end
    end

    assign clk_rise = clk_s[SYNC_STAGES-1] & ~clk_s[SYNC_STAGES];
    assign le_rise  = le_s[SYNC_STAGES-1]  & ~le_s[SYNC_STAGES];
    assign rt       = rt_s[SYNC_STAGES-1];
    assign cd       = cd_s[SYNC_STAGES-1];
    assign din      = din_s[SYNC_STAGES-1];
    assign src      = cd ? port.tc_in : port.td_in;
    assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            bit_cnt <= '0;
            ovr     <= 1'b0;
            to_cnt  <= '0;
            cap_q   <= '0;
            cap_cnt <= '0;
            dout_q  <= 1'b0;
            rd_q    <= '0;
            rc_q    <= '0;
            rd_stb  <= 1'b0;
            rc_stb  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            bit_cnt <= bit_cnt_n;
            ovr     <= ovr_n;
            to_cnt  <= to_cnt_n;
            cap_q   <= cap_q_n;
            cap_cnt <= cap_cnt_n;
            dout_q  <= dout_n;
            rd_q    <= rd_n;
            rc_q    <= rc_n;
            rd_stb  <= rd_stb_n;
            rc_stb  <= rc_stb_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        sh_n      = sh;
        bit_cnt_n = bit_cnt;
        ovr_n     = ovr;
        to_cnt_n  = to_cnt;
        cap_q_n   = cap_q;
        cap_cnt_n = cap_cnt;
        dout_n    = dout_q;
        rd_n      = rd_q;
        rc_n      = rc_q;
        rd_stb_n  = 1'b0;
        rc_stb_n  = 1'b0;
        err_n     = 1'b0;

        case (state)
            IDLE: begin
                to_cnt_n = '0;
                if (le_rise) begin
                    if (rt) begin
                        state_n   = CAPTURE;
                        cap_cnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (clk_rise && !rt) begin
                    sh_n      = {7'b0, din};
                    bit_cnt_n = 4'd1;
                    ovr_n     = 1'b0;
                    state_n   = RX;
                end
            end

            CAPTURE: begin
                // the latch is asynchronous: accept it only once two samples agree
                to_cnt_n = '0;
                cap_q_n  = src;
                if ((cap_cnt != 3'd0) && (src == cap_q)) begin
                    sh_n      = src;
                    dout_n    = src[7];
                    bit_cnt_n = '0;
                    state_n   = TX;
                end else if (cap_cnt == 3'd7) begin
                    sh_n      = src;
                    dout_n    = src[7];
                    bit_cnt_n = '0;
                    err_n     = 1'b1;
                    state_n   = TX;
                end else begin
                    cap_cnt_n = cap_cnt + 3'd1;
                end
            end

            TX: begin
                if (le_rise) begin
                    err_n     = 1'b1;
                    dout_n    = 1'b0;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                    cap_cnt_n = '0;
                    state_n   = rt ? CAPTURE : IDLE;
                end else if (clk_rise) begin
                    to_cnt_n = '0;
                    if (bit_cnt == 4'd7) begin
                        dout_n    = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                    end else begin
                        sh_n      = {sh[6:0], 1'b0};
                        dout_n    = sh[6];
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end else if (to_hit) begin
                    err_n     = 1'b1;
                    dout_n    = 1'b0;
                    bit_cnt_n = '0;
                    ovr_n     = 1'b0;
                    to_cnt_n  = '0;
                    state_n   = IDLE;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end

            RX: begin
                if (le_rise) begin
                    ovr_n     = 1'b0;
                    bit_cnt_n = '0;
                    to_cnt_n  = '0;
                    if (rt) begin
                        err_n     = 1'b1;
                        cap_cnt_n = '0;
                        state_n   = CAPTURE;
                    end else if ((bit_cnt == 4'd8) && !ovr) begin
                        if (cd) begin
                            rc_n     = sh;
                            rc_stb_n = 1'b1;
                        end else begin
                            rd_n     = sh;
                            rd_stb_n = 1'b1;
                        end
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end else if (clk_rise) begin
                    to_cnt_n = '0;
                    sh_n     = {sh[6:0], din};
                    if (bit_cnt == 4'd8) ovr_n = 1'b1;
                    else                 bit_cnt_n = bit_cnt + 4'd1;
                end else if (to_hit) begin
                    err_n     = 1'b1;
                    dout_n    = 1'b0;
                    bit_cnt_n = '0;
                    ovr_n     = 1'b0;
                    to_cnt_n  = '0;
                    state_n   = IDLE;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign port.r_dout    = dout_q;
    assign port.rd_out    = rd_q;
    assign port.rc_out    = rc_q;
    assign port.rd_strobe = rd_stb;
    assign port.rc_strobe = rc_stb;
    assign port.frame_err = err;
    assign port.busy      = (state != IDLE);

endmodule

// File: tb/tb_tipi_rpi_shift_port.sv
// Bench for tipi_rpi_shift_port: directed RPi frames, strobe/error events scoreboarded by a monitor.
module tb_tipi_rpi_shift_port;
    localparam int TO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    tipi_rpi_shift_port_if ifc();

    tipi_rpi_shift_port #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .port(ifc)
    );

    typedef struct packed {
        logic [1:0] kind;   // 0 = rd strobe, 1 = rc strobe, 2 = frame error
        logic [7:0] val;
    } ev_t;

    ev_t q[$];
    int  errors = 0;
    int  checks = 0;

    logic       tog = 1'b0;
    logic       tog_val = 1'b0;
    logic [7:0] td_val = 8'h00;
    logic [7:0] last_td = 8'h00;
    logic [7:0] err_td = 8'h00;

    assign ifc.td_in = tog ? {8{tog_val}} : td_val;

    always @(negedge clk) tog_val <= ~tog_val;
    always @(posedge clk) last_td <= ifc.td_in;

    // Monitor: every output event must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && (ifc.rd_strobe || ifc.rc_strobe || ifc.frame_err)) begin
            ev_t got;
            got.kind = ifc.frame_err ? 2'd2 : (ifc.rc_strobe ? 2'd1 : 2'd0);
            got.val  = ifc.frame_err ? 8'h00 : (ifc.rc_strobe ? ifc.rc_out : ifc.rd_out);
            if (ifc.frame_err) err_td = last_td;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got kind=%0d val=%h, required none", got.kind, got.val);
            end else begin
                ev_t exp;
                exp = q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL event: got kind=%0d val=%h, required kind=%0d val=%h",
                             got.kind, got.val, exp.kind, exp.val);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic drain(input string nm, input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            cyc(1);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: pending=%0d, required 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic clk_pulse(input logic d);
        ifc.r_din = d;
        cyc(2);
        ifc.r_clk = 1'b1;
        cyc(4);
        ifc.r_clk = 1'b0;
        cyc(4);
    endtask

    task automatic le_pulse();
        ifc.r_le = 1'b1;
        cyc(4);
        ifc.r_le = 1'b0;
        cyc(4);
    endtask

    task automatic wr_bits(input logic [7:0] v, input int n, input logic cd);
        ifc.r_rt = 1'b0;
        ifc.r_cd = cd;
        cyc(4);
        for (int i = 0; i < n; i++) clk_pulse(i < 8 ? v[7-i] : 1'b0);
    endtask

    task automatic rd_byte(input string nm, input logic [7:0] exp);
        for (int i = 7; i >= 0; i--) begin
            checks++;
            if (ifc.r_dout !== exp[i]) begin
                errors++;
                $display("FAIL %s_bit%0d: got %b, required %b", nm, i, ifc.r_dout, exp[i]);
            end
            clk_pulse(1'b0);
        end
    endtask

    initial begin
        ifc.r_clk = 1'b0; ifc.r_le = 1'b0; ifc.r_rt = 1'b0;
        ifc.r_cd  = 1'b0; ifc.r_din = 1'b0; ifc.tc_in = 8'h00;
        cyc(3);
        chk("rst_rd_out", ifc.rd_out, 8'h00);
        chk("rst_rc_out", ifc.rc_out, 8'h00);
        chk("rst_misc", {3'b0, ifc.r_dout, ifc.busy, ifc.rd_strobe, ifc.rc_strobe, ifc.frame_err}, 8'h00);
        rst_n = 1'b1;
        cyc(3);
        chk("idle_busy", {7'b0, ifc.busy}, 8'h00);

        // write data 0xA5
        wr_bits(8'hA5, 8, 1'b0);
        chk("rx_busy", {7'b0, ifc.busy}, 8'h01);
        expect_ev(2'd0, 8'hA5);
        le_pulse();
        drain("wr_a5", 20);
        chk("wr_rd_out", ifc.rd_out, 8'hA5);
        chk("wr_rc_out", ifc.rc_out, 8'h00);

        // read control 0x3C
        ifc.tc_in = 8'h3C;
        ifc.r_rt = 1'b1;
        ifc.r_cd = 1'b1;
        cyc(4);
        le_pulse();
        cyc(4);
        chk("tx_busy", {7'b0, ifc.busy}, 8'h01);
        rd_byte("rd_3c", 8'h3C);
        chk("rd_busy_after", {7'b0, ifc.busy}, 8'h00);
        chk("rd_dout_after", {7'b0, ifc.r_dout}, 8'h00);

        // short (5) and long (9) writes
        wr_bits(8'hFF, 5, 1'b0);
        expect_ev(2'd2, 8'h00);
        le_pulse();
        drain("short", 20);
        chk("short_rd_out", ifc.rd_out, 8'hA5);
        wr_bits(8'h0F, 9, 1'b0);
        expect_ev(2'd2, 8'h00);
        le_pulse();
        drain("long", 20);
        chk("long_rd_out", ifc.rd_out, 8'hA5);

        // timeout recovery, then a control write
        wr_bits(8'hE0, 3, 1'b0);
        expect_ev(2'd2, 8'h00);
        cyc(150);
        chk("to_not_early", 8'(q.size()), 8'd1);
        drain("timeout", TO);
        chk("to_busy", {7'b0, ifc.busy}, 8'h00);
        wr_bits(8'h5A, 8, 1'b1);
        expect_ev(2'd1, 8'h5A);
        le_pulse();
        drain("wr_5a", 20);
        chk("to_rc_out", ifc.rc_out, 8'h5A);
        chk("to_rd_out", ifc.rd_out, 8'hA5);

        // unstable data latch
        ifc.r_rt = 1'b1;
        ifc.r_cd = 1'b0;
        tog = 1'b1;
        cyc(4);
        expect_ev(2'd2, 8'h00);
        le_pulse();
        drain("unstable", 12);
        tog = 1'b0;
        td_val = ~err_td;
        cyc(2);
        rd_byte("rd_unstable", err_td);
        chk("unstable_busy", {7'b0, ifc.busy}, 8'h00);

        // coincident clk/le after a full byte: le wins, so the byte commits
        wr_bits(8'hC3, 8, 1'b0);
        expect_ev(2'd0, 8'hC3);
        ifc.r_clk = 1'b1;
        ifc.r_le  = 1'b1;
        cyc(4);
        ifc.r_clk = 1'b0;
        ifc.r_le  = 1'b0;
        cyc(4);
        drain("coincident", 20);
        chk("coinc_rd_out", ifc.rd_out, 8'hC3);

        // async reset in the middle of a write
        wr_bits(8'hF0, 4, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rd_out", ifc.rd_out, 8'h00);
        chk("arst_rc_out", ifc.rc_out, 8'h00);
        chk("arst_misc", {3'b0, ifc.r_dout, ifc.busy, ifc.rd_strobe, ifc.rc_strobe, ifc.frame_err}, 8'h00);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        wr_bits(8'h81, 8, 1'b0);
        expect_ev(2'd0, 8'h81);
        le_pulse();
        drain("post_rst", 20);
        chk("post_rst_rd_out", ifc.rd_out, 8'h81);
        chk("post_rst_rc_out", ifc.rc_out, 8'h00);

        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
